// File: rtl/mem_stage_pkg.sv
// Shared opcode encodings, branch masks and reset constants for the
// scalar pipeline memory stage.
package mem_stage_pkg;

  localparam int REG_WIDTH_DEF    = 16;
  localparam int PC_WIDTH_DEF     = 16;
  localparam int OPCODE_WIDTH_DEF = 8;

  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_ADD_D  = 8'h00;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_ADDI_D = 8'h01;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_AND_D  = 8'h02;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_ANDI_D = 8'h03;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_MOV    = 8'h04;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_MOVI_D = 8'h05;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_LDW    = 8'h10;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_STW    = 8'h11;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_BRN    = 8'h20;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_BRZ    = 8'h21;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_BRP    = 8'h22;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_BRNZ   = 8'h23;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_BRNP   = 8'h24;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_BRZP   = 8'h25;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_BRNZP  = 8'h26;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_JMP    = 8'h30;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_JSR    = 8'h31;
  localparam logic [OPCODE_WIDTH_DEF-1:0] OP_JSRR   = 8'h32;

  localparam logic [2:0] NZP_N   = 3'b100;
  localparam logic [2:0] NZP_Z   = 3'b010;
  localparam logic [2:0] NZP_P   = 3'b001;
  localparam logic [2:0] CC_RESET = NZP_Z;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } mem_state_e;

  // Zero for anything that is not a conditional branch.
  function automatic logic [2:0] nzp_mask(input logic [OPCODE_WIDTH_DEF-1:0] op);
    case (op)
      OP_BRN:   return NZP_N;
      OP_BRZ:   return NZP_Z;
      OP_BRP:   return NZP_P;
      OP_BRNZ:  return NZP_N | NZP_Z;
      OP_BRNP:  return NZP_N | NZP_P;
      OP_BRZP:  return NZP_Z | NZP_P;
      OP_BRNZP: return NZP_N | NZP_Z | NZP_P;
      default:  return 3'b000;
    endcase
  endfunction

  function automatic logic is_alu_op(input logic [OPCODE_WIDTH_DEF-1:0] op);
    return (op == OP_ADD_D) || (op == OP_ADDI_D) || (op == OP_AND_D) ||
           (op == OP_ANDI_D) || (op == OP_MOV) || (op == OP_MOVI_D);
  endfunction

  function automatic logic is_jump_op(input logic [OPCODE_WIDTH_DEF-1:0] op);
    return (op == OP_JMP) || (op == OP_JSR) || (op == OP_JSRR);
  endfunction

endpackage

// File: rtl/mem_stage_mem_req_fsm.sv
// Data-memory request sequencer: holds one LDW/STW request until it is
// acknowledged or times out, and reports which of the two ended it.
module mem_req_fsm
  import mem_stage_pkg::*;
#(
  parameter int REG_WIDTH   = REG_WIDTH_DEF,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 start_i,
  input  logic                 start_we_i,
  input  logic [REG_WIDTH-1:0] start_addr_i,
  input  logic [REG_WIDTH-1:0] start_wdata_i,
  input  logic                 ack_i,
  output logic                 req_o,
  output logic                 we_o,
  output logic [REG_WIDTH-1:0] addr_o,
  output logic [REG_WIDTH-1:0] wdata_o,
  output logic                 ready_o,
  output logic                 ack_fire_o,
  output logic                 timeout_fire_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  mem_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  // The edge that would take the counter to MEM_TIMEOUT is the abort edge;
  // an ack on that same edge takes priority.
  assign ack_fire_o     = (state_q == ST_MEM_WAIT) && ack_i;
  assign timeout_fire_o = (state_q == ST_MEM_WAIT) && !ack_i && (cnt_q == CNT_LAST);

  always_ff @(negedge clk) begin
    if (srst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_o   <= 1'b0;
      we_o    <= 1'b0;
      addr_o  <= '0;
      wdata_o <= '0;
      ready_o <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_MEM_WAIT;
            cnt_q   <= '0;
            req_o   <= 1'b1;
            we_o    <= start_we_i;
            addr_o  <= start_addr_i;
            wdata_o <= start_wdata_i;
            ready_o <= 1'b0;
          end
        end
        ST_MEM_WAIT: begin
          if (ack_fire_o || timeout_fire_o) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_o   <= 1'b0;
            we_o    <= 1'b0;
            ready_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_o   <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the scalar pipeline: LDW/STW via req/ack, branch and jump
// redirects against the condition codes, and retirement to writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int REG_WIDTH    = REG_WIDTH_DEF,
  parameter int PC_WIDTH     = PC_WIDTH_DEF,
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET,
  input  logic                    I_LOCK,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [REG_WIDTH-1:0]    I_ALUOut,
  input  logic [3:0]              I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]    I_DestValue,
  input  logic                    I_FetchStall,
  input  logic                    I_DepStall,
  output logic                    O_Ready,
  output logic                    O_DMemReq,
  output logic                    O_DMemWe,
  output logic [REG_WIDTH-1:0]    O_DMemAddr,
  output logic [REG_WIDTH-1:0]    O_DMemWData,
  input  logic                    I_DMemAck,
  input  logic [REG_WIDTH-1:0]    I_DMemRData,
  output logic                    O_LOCK,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [3:0]              O_DestRegIdx,
  output logic                    O_RegWE,
  output logic [REG_WIDTH-1:0]    O_WBValue,
  output logic                    O_BranchTaken,
  output logic [PC_WIDTH-1:0]     O_BranchTarget,
  output logic [2:0]              O_CC,
  output logic                    O_MemError
);

  logic                    accept;
  logic                    bubble_in;
  logic                    is_mem;
  logic                    mem_start;
  logic [2:0]              br_mask;
  logic                    ack_fire;
  logic                    timeout_fire;
  logic [OPCODE_WIDTH-1:0] held_op_q;
  logic [3:0]              held_idx_q;

  function automatic logic [2:0] cc_of(input logic [REG_WIDTH-1:0] v);
    if (v[REG_WIDTH-1]) return NZP_N;
    else if (v == '0)   return NZP_Z;
    else                return NZP_P;
  endfunction

  assign accept    = I_LOCK && O_Ready;
  assign bubble_in = I_FetchStall || I_DepStall;
  assign is_mem    = (I_Opcode == OP_LDW) || (I_Opcode == OP_STW);
  assign mem_start = accept && !bubble_in && is_mem && !I_ALUOut[0];
  assign br_mask   = nzp_mask(I_Opcode);

  mem_req_fsm #(
    .REG_WIDTH  (REG_WIDTH),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_req (
    .clk           (I_CLOCK),
    .srst          (I_RESET),
    .start_i       (mem_start),
    .start_we_i    (I_Opcode == OP_STW),
    .start_addr_i  (I_ALUOut),
    .start_wdata_i (I_DestValue),
    .ack_i         (I_DMemAck),
    .req_o         (O_DMemReq),
    .we_o          (O_DMemWe),
    .addr_o        (O_DMemAddr),
    .wdata_o       (O_DMemWData),
    .ready_o       (O_Ready),
    .ack_fire_o    (ack_fire),
    .timeout_fire_o(timeout_fire)
  );

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      O_LOCK         <= 1'b0;
      O_Opcode       <= '0;
      O_DestRegIdx   <= '0;
      O_RegWE        <= 1'b0;
      O_WBValue      <= '0;
      O_BranchTaken  <= 1'b0;
      O_BranchTarget <= '0;
      O_CC           <= CC_RESET;
      O_MemError     <= 1'b0;
      held_op_q      <= '0;
      held_idx_q     <= '0;
    end else begin
      O_LOCK        <= 1'b0;
      O_RegWE       <= 1'b0;
      O_BranchTaken <= 1'b0;
      if (mem_start) begin
        held_op_q  <= I_Opcode;
        held_idx_q <= I_DestRegIdx;
      end
      // Accept is impossible while an access is outstanding (O_Ready=0), so
      // ack/timeout retirement never collides with a new bundle.
      if (ack_fire) begin
        O_LOCK       <= 1'b1;
        O_Opcode     <= held_op_q;
        O_DestRegIdx <= held_idx_q;
        if (!O_DMemWe) begin
          O_RegWE   <= 1'b1;
          O_WBValue <= I_DMemRData;
          O_CC      <= cc_of(I_DMemRData);
        end
      end else if (timeout_fire) begin
        O_LOCK       <= 1'b1;
        O_Opcode     <= held_op_q;
        O_DestRegIdx <= held_idx_q;
        O_MemError   <= 1'b1;
      end else if (accept) begin
        O_LOCK       <= !mem_start;
        O_Opcode     <= I_Opcode;
        O_DestRegIdx <= I_DestRegIdx;
        if (!bubble_in) begin
          if (is_alu_op(I_Opcode)) begin
            O_RegWE   <= 1'b1;
            O_WBValue <= I_ALUOut;
            O_CC      <= cc_of(I_ALUOut);
          end else if ((br_mask != 3'b000 && (br_mask & O_CC) != 3'b000) ||
                       is_jump_op(I_Opcode)) begin
            O_BranchTaken  <= 1'b1;
            O_BranchTarget <= I_ALUOut[PC_WIDTH-1:0];
          end else if (is_mem && I_ALUOut[0]) begin
            O_MemError <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle bundles followed by
// hand-written load/store, timeout, misalignment and reset sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        lock_i;
  logic [7:0]  op_i;
  logic [15:0] alu_i;
  logic [3:0]  idx_i;
  logic [15:0] dval_i;
  logic        fst_i, dst_i;
  logic        ready, req, we;
  logic [15:0] addr, wdata;
  logic        ack;
  logic [15:0] rdata;
  logic        lock_o;
  logic [7:0]  op_o;
  logic [3:0]  idx_o;
  logic        regwe;
  logic [15:0] wb;
  logic        br;
  logic [15:0] tgt;
  logic [2:0]  cc;
  logic        merr;

  int n_total = 0;
  int n_pass  = 0;

  mem_stage #(.MEM_TIMEOUT(4)) dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock_i), .I_Opcode(op_i),
    .I_ALUOut(alu_i), .I_DestRegIdx(idx_i), .I_DestValue(dval_i),
    .I_FetchStall(fst_i), .I_DepStall(dst_i), .O_Ready(ready),
    .O_DMemReq(req), .O_DMemWe(we), .O_DMemAddr(addr), .O_DMemWData(wdata),
    .I_DMemAck(ack), .I_DMemRData(rdata), .O_LOCK(lock_o), .O_Opcode(op_o),
    .O_DestRegIdx(idx_o), .O_RegWE(regwe), .O_WBValue(wb),
    .O_BranchTaken(br), .O_BranchTarget(tgt), .O_CC(cc), .O_MemError(merr)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] alu;
    logic        fst;
    logic        dst;
    logic        e_we;
    logic [15:0] e_wb;
    logic        e_br;
    logic [15:0] e_tgt;
    logic [2:0]  e_cc;
  } vec_t;

  vec_t vec [17];

  // State updates on the falling edge; sample and drive 1 time unit later.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [7:0] op, input logic [15:0] alu,
                       input logic [15:0] dval, input logic [3:0] idx);
    lock_i = 1'b1; op_i = op; alu_i = alu; dval_i = dval; idx_i = idx;
    fst_i = 1'b0; dst_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; lock_i = 1'b0; op_i = '0; alu_i = '0; idx_i = '0; dval_i = '0;
    fst_i = 1'b0; dst_i = 1'b0; ack = 1'b0; rdata = '0;

    vec[0]  = '{OP_ADDI_D, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 3'b010};
    vec[1]  = '{OP_BRZ,    16'h0040, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 3'b010};
    vec[2]  = '{OP_MOVI_D, 16'hFFFE, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 3'b100};
    vec[3]  = '{OP_BRP,    16'h0080, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b100};
    vec[4]  = '{OP_BRNZP,  16'h0090, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0090, 3'b100};
    vec[5]  = '{OP_ADD_D,  16'h0005, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 16'h0000, 3'b001};
    vec[6]  = '{OP_BRNZ,   16'h00A0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b001};
    vec[7]  = '{OP_BRP,    16'h00B0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h00B0, 3'b001};
    vec[8]  = '{OP_ADD_D,  16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b001};
    vec[9]  = '{OP_JMP,    16'h1230, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1230, 3'b001};
    vec[10] = '{OP_AND_D,  16'h8000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b001};
    vec[11] = '{8'hFF,     16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b001};
    vec[12] = '{OP_ANDI_D, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 16'h0000, 3'b100};
    vec[13] = '{OP_BRN,    16'h00C0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h00C0, 3'b100};
    vec[14] = '{OP_JSR,    16'h0100, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100, 3'b100};
    vec[15] = '{OP_JSRR,   16'h0200, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0200, 3'b100};
    vec[16] = '{OP_BRZP,   16'h0300, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b100};

    tick();
    do_reset();
    chk("rst_ready", ready, 1);
    chk("rst_cc", cc, 3'b010);
    chk("rst_req", req, 0);
    chk("rst_lock", lock_o, 0);
    chk("rst_merr", merr, 0);
    chk("rst_br", br, 0);
    chk("rst_wb", wb, 0);
    $display("reset done: ready=%0d cc=%03b", ready, cc);

    for (int i = 0; i < 17; i++) begin
      drive(vec[i].op, vec[i].alu, 16'h0000, 4'(i));
      fst_i = vec[i].fst; dst_i = vec[i].dst;
      tick();
      chk($sformatf("v%0d_lock", i), lock_o, 1);
      chk($sformatf("v%0d_we", i), regwe, vec[i].e_we);
      chk($sformatf("v%0d_br", i), br, vec[i].e_br);
      chk($sformatf("v%0d_cc", i), cc, vec[i].e_cc);
      if (vec[i].e_we)  chk($sformatf("v%0d_wb", i), wb, vec[i].e_wb);
      if (vec[i].e_br)  chk($sformatf("v%0d_tgt", i), tgt, vec[i].e_tgt);
      $display("vec %0d op=%02h alu=%04h -> we=%0d wb=%04h br=%0d tgt=%04h cc=%03b",
               i, vec[i].op, vec[i].alu, regwe, wb, br, tgt, cc);
    end

    lock_i = 1'b0;
    tick();
    chk("idle_lock", lock_o, 0);
    chk("idle_br", br, 0);
    chk("idle_we", regwe, 0);

    // LDW with ack on the third edge after the request.
    drive(OP_LDW, 16'h0010, 16'h0000, 4'd3);
    tick();
    chk("ldw_req", req, 1);
    chk("ldw_we", we, 0);
    chk("ldw_addr", addr, 16'h0010);
    chk("ldw_lock0", lock_o, 0);
    chk("ldw_ready0", ready, 0);
    drive(OP_ADDI_D, 16'h0007, 16'h0000, 4'd5);
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk($sformatf("ldw_ready%0d", k), ready, 0);
      chk($sformatf("ldw_req%0d", k), req, 1);
      chk($sformatf("ldw_lock%0d", k), lock_o, 0);
    end
    ack = 1'b1; rdata = 16'h1234;
    tick();
    ack = 1'b0;
    chk("ldw_ret_lock", lock_o, 1);
    chk("ldw_ret_we", regwe, 1);
    chk("ldw_ret_wb", wb, 16'h1234);
    chk("ldw_ret_cc", cc, 3'b001);
    chk("ldw_ret_idx", idx_o, 3);
    chk("ldw_ret_op", op_o, OP_LDW);
    chk("ldw_ret_ready", ready, 1);
    chk("ldw_ret_req", req, 0);
    $display("ldw retire wb=%04h cc=%03b", wb, cc);
    tick();
    chk("held_add_wb", wb, 16'h0007);
    chk("held_add_idx", idx_o, 5);

    // STW: request fields stay put while upstream presents a new bundle.
    drive(OP_STW, 16'h0020, 16'hBEEF, 4'd1);
    tick();
    chk("stw_req", req, 1);
    chk("stw_we", we, 1);
    chk("stw_addr", addr, 16'h0020);
    chk("stw_wdata", wdata, 16'hBEEF);
    drive(OP_ADD_D, 16'h9999, 16'h1111, 4'd2);
    tick();
    chk("stw_hold_addr", addr, 16'h0020);
    chk("stw_hold_wdata", wdata, 16'hBEEF);
    chk("stw_hold_we", we, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("stw_ret_lock", lock_o, 1);
    chk("stw_ret_we", regwe, 0);
    chk("stw_ret_req", req, 0);
    chk("stw_ret_cc", cc, 3'b001);
    $display("stw retire lock=%0d regwe=%0d", lock_o, regwe);
    tick();
    chk("after_stw_wb", wb, 16'h9999);
    chk("after_stw_cc", cc, 3'b100);

    // Ack on the timeout edge wins.
    drive(OP_LDW, 16'h0050, 16'h0000, 4'd4);
    tick();
    lock_i = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    chk("race_req3", req, 1);
    ack = 1'b1; rdata = 16'h0000;
    tick();
    ack = 1'b0;
    chk("race_we", regwe, 1);
    chk("race_cc", cc, 3'b010);
    chk("race_merr", merr, 0);
    chk("race_req", req, 0);
    $display("ack-on-timeout-edge: regwe=%0d merr=%0d", regwe, merr);

    // No ack: abort on the fourth edge.
    drive(OP_LDW, 16'h0060, 16'h0000, 4'd6);
    tick();
    lock_i = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    chk("to_req3", req, 1);
    chk("to_merr3", merr, 0);
    tick();
    chk("to_req", req, 0);
    chk("to_merr", merr, 1);
    chk("to_lock", lock_o, 1);
    chk("to_we", regwe, 0);
    chk("to_ready", ready, 1);
    chk("to_cc", cc, 3'b010);
    $display("timeout: req=%0d merr=%0d", req, merr);
    tick();
    chk("merr_sticky", merr, 1);

    // Misaligned access never reaches memory.
    do_reset();
    chk("rst2_merr", merr, 0);
    drive(OP_LDW, 16'h0011, 16'h0000, 4'd7);
    tick();
    lock_i = 1'b0;
    chk("mis_req", req, 0);
    chk("mis_merr", merr, 1);
    chk("mis_lock", lock_o, 1);
    chk("mis_we", regwe, 0);
    chk("mis_ready", ready, 1);
    $display("misaligned: req=%0d merr=%0d", req, merr);

    // Reset in the middle of an access; a late ack is ignored.
    do_reset();
    drive(OP_LDW, 16'h0040, 16'h0000, 4'd8);
    tick();
    lock_i = 1'b0;
    chk("mid_req", req, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_merr", merr, 0);
    chk("mid_rst_lock", lock_o, 0);
    ack = 1'b1; rdata = 16'h5555;
    tick();
    chk("late_ack_lock", lock_o, 0);
    chk("late_ack_we", regwe, 0);
    tick();
    ack = 1'b0;
    chk("late_ack_lock2", lock_o, 0);
    chk("late_ack_cc", cc, 3'b010);
    $display("reset mid-access: req=%0d ready=%0d lock=%0d", req, ready, lock_o);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
